alu_sequencer: RTL

Multi-cycle controller that drives the 16-bit combinational ALU (Fn: 00 ADD, 01 AND, 10 NOT A, 11 PASS A) to perform both native and composite operations.
- Composite ops are SUB, OR, SHL and MUL. Each is built from a sequence of native ALU steps, using internal temporaries.
- Sits between the control unit and the ALU. Owns the ALU input muxing and Fn select while busy.
- Start/Ready/Done handshake toward the control unit.

---
 rtl/alu_sequencer.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/alu_sequencer.sv
// Multi-cycle controller for a 16-bit combinational ALU (ADD/AND/NOT/PASS).
// It builds SUB, OR, SHL and MUL from sequences of native ALU steps and uses a Start/Ready/Done handshake.
module alu_sequencer #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] OpA,
  input  logic [WIDTH-1:0] OpB,
  output logic             Ready,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] AluA,
  output logic [WIDTH-1:0] AluB,
  output logic [1:0]       AluFn,
  input  logic [WIDTH-1:0] AluOut
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_FINISH} state_e;
  typedef enum logic [2:0] {
    OP_ADD, OP_AND, OP_NOT, OP_PASS, OP_SUB, OP_OR, OP_SHL, OP_MUL
  } op_e;
  typedef enum logic [1:0] {FN_ADD, FN_AND, FN_NOT, FN_PASS} fn_e;

  state_e           r_state, w_state_nx;
  op_e              r_op;
  logic [WIDTH-1:0] r_a, r_b, r_t, r_u, r_p, r_m, r_q, r_result;
  logic [4:0]       r_cnt;
  logic             r_mul_add;

  logic [WIDTH-1:0] w_a, w_b, w_final;
  fn_e              w_fn;
  logic             w_wr_t, w_wr_u, w_last;

  always_comb begin
    w_state_nx = r_state;
    w_a        = '0;
    w_b        = '0;
    w_fn       = FN_PASS;
    w_wr_t     = 1'b0;
    w_wr_u     = 1'b0;
    w_last     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (Start) begin
          w_state_nx = (op_e'(Op) == OP_MUL && OpB == '0) ? S_FINISH : S_EXEC;
        end
      end
      S_EXEC: begin
        case (r_op)
          OP_ADD, OP_AND, OP_NOT, OP_PASS: begin
            w_a    = r_a;
            w_b    = r_b;
            w_fn   = fn_e'(r_op[1:0]);
            w_wr_t = 1'b1;
            w_last = 1'b1;
          end
          OP_SUB: begin
            w_wr_t = 1'b1;
            case (r_cnt)
              5'd0: begin w_a = r_b; w_fn = FN_NOT; end
              5'd1: begin w_a = r_t; w_b = WIDTH'(1); w_fn = FN_ADD; end
              default: begin w_a = r_a; w_b = r_t; w_fn = FN_ADD; w_last = 1'b1; end
            endcase
          end
          OP_OR: begin
            case (r_cnt)
              5'd0: begin w_a = r_a; w_fn = FN_NOT; w_wr_t = 1'b1; end
              5'd1: begin w_a = r_b; w_fn = FN_NOT; w_wr_u = 1'b1; end
              5'd2: begin w_a = r_t; w_b = r_u; w_fn = FN_AND; w_wr_t = 1'b1; end
              default: begin w_a = r_t; w_fn = FN_NOT; w_wr_t = 1'b1; w_last = 1'b1; end
            endcase
          end
          OP_SHL: begin
            w_wr_t = 1'b1;
            if (r_cnt == 5'd0) begin
              w_a  = r_a;
              w_fn = FN_PASS;
            end else begin
              w_a  = r_t;
              w_b  = r_t;
              w_fn = FN_ADD;
            end
            w_last = (r_cnt[3:0] == r_b[3:0]);
          end
          OP_MUL: begin
            // Alternates accumulate (when Q[0]=1) and doubling; finishes after the doubling that empties Q.
            w_fn = FN_ADD;
            if (r_mul_add) begin
              w_a = r_p;
              w_b = r_m;
            end else begin
              w_a    = r_m;
              w_b    = r_m;
              w_last = (r_q[WIDTH-1:1] == '0);
            end
          end
        endcase
        if (w_last) w_state_nx = S_FINISH;
      end
      S_FINISH: w_state_nx = S_IDLE;
      default:  w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state   <= S_IDLE;
      r_op      <= OP_ADD;
      r_a       <= '0;
      r_b       <= '0;
      r_t       <= '0;
      r_u       <= '0;
      r_p       <= '0;
      r_m       <= '0;
      r_q       <= '0;
      r_cnt     <= '0;
      r_mul_add <= 1'b0;
      r_result  <= '0;
    end else begin
      r_state <= w_state_nx;
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            r_op      <= op_e'(Op);
            r_a       <= OpA;
            r_b       <= OpB;
            r_cnt     <= '0;
            r_p       <= '0;
            r_m       <= OpA;
            r_q       <= OpB;
            r_mul_add <= OpB[0];
          end
        end
        S_EXEC: begin
          r_cnt <= r_cnt + 5'd1;
          if (w_wr_t) r_t <= AluOut;
          if (w_wr_u) r_u <= AluOut;
          if (r_op == OP_MUL) begin
            if (r_mul_add) begin
              r_p       <= AluOut;
              r_mul_add <= 1'b0;
            end else begin
              r_m       <= AluOut;
              r_q       <= r_q >> 1;
              r_mul_add <= r_q[1];
            end
          end
        end
        S_FINISH: r_result <= w_final;
        default: ;
      endcase
    end
  end

  assign w_final = (r_op == OP_MUL) ? r_p : r_t;
  assign Ready   = (r_state == S_IDLE);
  assign Done    = (r_state == S_FINISH);
  // Result is visible during the Done cycle and then held in r_result.
  assign Result  = (r_state == S_FINISH) ? w_final : r_result;
  assign AluA    = w_a;
  assign AluB    = w_b;
  assign AluFn   = w_fn;

endmodule
